// File: rtl/sys_parameter_pkg.sv
// Shared constants and types for the SYS_Parameter handshake block.
//   - Avalon word addresses, status/control bit positions, ID word
//   - handshake FSM state encoding
package sys_parameter_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_ID     = 2'd3;

  localparam int STAT_UNDERFLOW  = 16;
  localparam int STAT_TIMEOUT    = 17;

  localparam int CTRL_FLUSH      = 0;
  localparam int CTRL_CLR_STICKY = 1;

  // "PHS1"
  localparam logic [31:0] PARAM_HS_ID = 32'h5048_5331;

  typedef enum logic [1:0] {
    HOLDOFF = 2'd0,
    IDLE    = 2'd1,
    NOTIFY  = 2'd2,
    RELEASE = 2'd3
  } hs_state_t;

endpackage

// File: rtl/sys_parameter_handshake_fifo.sv
// param_fifo: synchronous word FIFO.
//   clk, reset_n      clock / async active-low reset
//   push, wdata       enqueue (ignored when full or flushing)
//   pop               dequeue (ignored when empty or flushing)
//   flush             empty the FIFO; wins over push and pop
//   head              word at the read pointer (stale when empty)
//   count, full, empty occupancy
module param_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full  & ~flush;
  assign do_pop  = pop  & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sys_parameter_handshake.sv
// sys_parameter_handshake: buffers observer parameter words and notifies the
// CPU through the SYS_Parameter GPIO by pulling notify_n low; the CPU drains
// words over Avalon-MM and acknowledges by pulsing the GPIO out_port (ack_in).
//   clk, reset_n                   clock / async active-low reset
//   s_valid, s_data, s_ready       producer stream (s_ready = ~full)
//   address, chipselect, read_n,
//   write_n, writedata, readdata   Avalon-MM slave, readdata latency 1
//   notify_n                       to GPIO in_port, low = words pending
//   ack_in                         from GPIO out_port
// Optional: define PARAM_HS_TIMEOUT_EN to release NOTIFY after
// TIMEOUT_CYCLES without an acknowledge and set the sticky timeout bit.
module sys_parameter_handshake
  import sys_parameter_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 8,
  parameter int MIN_HIGH       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              notify_n,
  input  logic              ack_in
);

  localparam int HW = $clog2(MIN_HIGH);

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0]      head;
  logic [$clog2(DEPTH):0] count;
  logic                   full, empty;
  logic                   push, pop, pop_req, flush, clr_sticky, ctrl_wr;

  assign s_ready    = ~full;
  assign push       = s_valid & s_ready;
  assign pop_req    = chipselect & ~read_n & (address == ADDR_DATA);
  assign pop        = pop_req & ~empty;
  assign ctrl_wr    = chipselect & ~write_n & (address == ADDR_CTRL);
  assign flush      = ctrl_wr & writedata[CTRL_FLUSH];
  assign clr_sticky = ctrl_wr & writedata[CTRL_CLR_STICKY];

  param_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .wdata  (s_data),
    .pop    (pop),
    .flush  (flush),
    .head   (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // ------------------------------------------------------- sticky status
  logic underflow_q, timeout_q, tmo_hit;

  // A new event in the same cycle as a clear is kept so it is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (pop_req && empty) underflow_q <= 1'b1;
      else if (clr_sticky)  underflow_q <= 1'b0;
      if (tmo_hit)          timeout_q   <= 1'b1;
      else if (clr_sticky)  timeout_q   <= 1'b0;
    end
  end

  // -------------------------------------------------------- read decode
  logic [31:0] rd_mux, cnt32;

  assign cnt32 = 32'(count);

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:   if (!empty) rd_mux[DATA_W-1:0] = head;
      ADDR_STATUS: begin
        rd_mux[STAT_TIMEOUT]   = timeout_q;
        rd_mux[STAT_UNDERFLOW] = underflow_q;
        rd_mux[3:0]            = cnt32[3:0];
      end
      ADDR_CTRL:   rd_mux = 32'(DEPTH);
      default:     rd_mux = PARAM_HS_ID;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  // -------------------------------------------------------- handshake FSM
  hs_state_t     state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          ack_q, ack_rise, wdog_hit;

  assign ack_rise = ack_in & ~ack_q;

`ifdef PARAM_HS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wdog;

  // Counts cycles spent in NOTIFY; cleared in every other state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              wdog <= '0;
    else if (state != NOTIFY)  wdog <= '0;
    else                       wdog <= wdog + 1'b1;
  end

  assign wdog_hit = (state == NOTIFY) && (wdog == TW'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = '0;
    tmo_hit   = 1'b0;
    case (state)
      HOLDOFF: begin
        if (hcnt == HW'(MIN_HIGH - 1)) state_nxt = IDLE;
        else                           hcnt_nxt  = hcnt + 1'b1;
      end
      IDLE:    if (count != '0 && !ack_q) state_nxt = NOTIFY;
      NOTIFY: begin
        // Only an ack (or the watchdog) leaves NOTIFY; a flush does not.
        if (ack_rise) state_nxt = RELEASE;
        else if (wdog_hit) begin
          state_nxt = RELEASE;
          tmo_hit   = 1'b1;
        end
      end
      RELEASE: if (!ack_in) state_nxt = HOLDOFF;
      default: state_nxt = HOLDOFF;
    endcase
  end

  // notify_n is a pure register decode of the current state, so the line
  // never glitches and always sees HOLDOFF+IDLE high time before falling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HOLDOFF;
      hcnt     <= '0;
      ack_q    <= 1'b0;
      notify_n <= 1'b1;
    end else begin
      state    <= state_nxt;
      hcnt     <= hcnt_nxt;
      ack_q    <= ack_in;
      notify_n <= (state != NOTIFY);
    end
  end

endmodule
